// File: rtl/edp_diag_reader.sv
// EBUS-side diagnostic read sequencer: drives the diag function select lines to the
// EDP slices, waits for the bus to settle, then double-samples the assembled word.
module edp_diag_reader #(
  parameter int WIDTH         = 36,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             req_h,
  input  logic [2:0]       func_h,
  input  logic             abort_h,
  input  logic [WIDTH-1:0] ebus_d_h,
  output logic             diag_04_a_h,
  output logic             diag_05_a_h,
  output logic             diag_06_a_h,
  output logic             diag_read_func_12x_h,
  output logic             busy_h,
  output logic [WIDTH-1:0] data_h,
  output logic             done_h,
  output logic             err_h
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE1,
    SAMPLE2
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk_h) begin
    if (!reset_l) begin
      state                <= IDLE;
      cnt                  <= '0;
      diag_04_a_h          <= 1'b0;
      diag_05_a_h          <= 1'b0;
      diag_06_a_h          <= 1'b0;
      diag_read_func_12x_h <= 1'b0;
      busy_h               <= 1'b0;
      data_h               <= '0;
      done_h               <= 1'b0;
      err_h                <= 1'b0;
    end else begin
      done_h <= 1'b0;
      // Abort from any active state beats every transition, including completion.
      if (state != IDLE && abort_h) begin
        state                <= IDLE;
        diag_04_a_h          <= 1'b0;
        diag_05_a_h          <= 1'b0;
        diag_06_a_h          <= 1'b0;
        diag_read_func_12x_h <= 1'b0;
        busy_h               <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_h && !abort_h) begin
              {diag_04_a_h, diag_05_a_h, diag_06_a_h} <= func_h;
              diag_read_func_12x_h <= 1'b1;
              busy_h               <= 1'b1;
              cnt                  <= SETTLE_INIT;
              state                <= SETTLE;
            end
          end
          SETTLE: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= SAMPLE1;
          end
          SAMPLE1: begin
            data_h <= ebus_d_h;
            state  <= SAMPLE2;
          end
          SAMPLE2: begin
            err_h                <= (ebus_d_h != data_h);
            done_h               <= 1'b1;
            diag_04_a_h          <= 1'b0;
            diag_05_a_h          <= 1'b0;
            diag_06_a_h          <= 1'b0;
            diag_read_func_12x_h <= 1'b0;
            busy_h               <= 1'b0;
            state                <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
